// File: rtl/hazard_scoreboard.sv
// In-order RAW hazard / forwarding scoreboard beside decode.
// Tracks DEPTH post-decode stages; stalls decode and selects EX operand sources.
module hazard_scoreboard #(
    parameter int REG_BITS    = 3,
    parameter int DEPTH       = 3,
    parameter int FWD_EN      = 0,
    parameter int LOAD_STAGE  = 2,
    parameter int RF_BYPASS   = 1,
    parameter int FLUSH_DEPTH = 0,
    localparam int SEL_W      = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int NREG       = 2 ** REG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_reads_rs,
    input  logic                id_reads_rt,
    input  logic                id_writes,
    input  logic [REG_BITS-1:0] id_wreg,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [SEL_W-1:0]    ex_fwd_a_sel,
    output logic [SEL_W-1:0]    ex_fwd_b_sel,
    output logic [NREG-1:0]     pending,
    output logic [CW-1:0]       inflight_cnt
);

    logic [DEPTH-1:0]    v_q, v_d;
    logic [DEPTH-1:0]    w_q, w_d;
    logic [DEPTH-1:0]    ld_q, ld_d;
    logic [REG_BITS-1:0] wreg_q [DEPTH];
    logic [REG_BITS-1:0] wreg_d [DEPTH];
    logic [CW-1:0]       cnt_q [NREG];
    logic [CW-1:0]       cnt_d [NREG];
    logic [SEL_W-1:0]    sel_a_q, sel_b_q;
    logic [SEL_W-1:0]    sel_a_d, sel_b_d;

    logic fa, fb, la, lb, haz;
    int   ka, kb;

    // Youngest matching producer per source, hazard and forward select
    always_comb begin
        fa = 1'b0;
        fb = 1'b0;
        la = 1'b0;
        lb = 1'b0;
        ka = 0;
        kb = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && w_q[k] &&
                !((k == DEPTH - 1) && (RF_BYPASS != 0))) begin
                if (id_reads_rs && wreg_q[k] == id_rs) begin
                    fa = 1'b1;
                    ka = k;
                    la = ld_q[k];
                end
                if (id_reads_rt && wreg_q[k] == id_rt) begin
                    fb = 1'b1;
                    kb = k;
                    lb = ld_q[k];
                end
            end
        end
        if (FWD_EN == 0) begin
            haz = fa | fb;
        end else begin
            haz = (fa && la && (ka + 1 < LOAD_STAGE)) ||
                  (fb && lb && (kb + 1 < LOAD_STAGE));
        end
        sel_a_d = '0;
        sel_b_d = '0;
        if (FWD_EN != 0 && fa && (ka + 1 <= DEPTH - 1))
            sel_a_d = SEL_W'(ka + 1);
        if (FWD_EN != 0 && fb && (kb + 1 <= DEPTH - 1))
            sel_b_d = SEL_W'(kb + 1);
        stall = id_valid & haz & ~flush & ~rst;
        issue = id_valid & ~haz & ~flush & ~rst;
    end

    // Next stage entries: shift, load stage 0, squash flushed young stages
    always_comb begin
        v_d[0]    = issue;
        w_d[0]    = id_writes;
        ld_d[0]   = id_is_load;
        wreg_d[0] = id_wreg;
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]    = v_q[k-1] & ~(flush && (k - 1 < FLUSH_DEPTH));
            w_d[k]    = w_q[k-1];
            ld_d[k]   = ld_q[k-1];
            wreg_d[k] = wreg_q[k-1];
        end
    end

    // Per-register in-flight writer counts
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && id_writes && id_wreg == REG_BITS'(r))
                cnt_d[r] = cnt_d[r] + CW'(1);
            if (v_q[DEPTH-1] && w_q[DEPTH-1] &&
                wreg_q[DEPTH-1] == REG_BITS'(r))
                cnt_d[r] = cnt_d[r] - CW'(1);
            for (int k = 0; k < FLUSH_DEPTH; k++) begin
                if (flush && v_q[k] && w_q[k] &&
                    wreg_q[k] == REG_BITS'(r))
                    cnt_d[r] = cnt_d[r] - CW'(1);
            end
        end
    end

    // Status outputs derived from counters and valid bits
    always_comb begin
        inflight_cnt = '0;
        for (int k = 0; k < DEPTH; k++)
            inflight_cnt = inflight_cnt + CW'(v_q[k]);
        for (int r = 0; r < NREG; r++)
            pending[r] = (cnt_q[r] != '0);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else begin
            v_q     <= v_d;
            sel_a_q <= issue ? sel_a_d : '0;
            sel_b_q <= issue ? sel_b_d : '0;
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    // Entry payload, qualified by valid
    always_ff @(posedge clk) begin
        w_q  <= w_d;
        ld_q <= ld_d;
        for (int k = 0; k < DEPTH; k++)
            wreg_q[k] <= wreg_d[k];
    end

    assign ex_fwd_a_sel = sel_a_q;
    assign ex_fwd_b_sel = sel_b_q;

endmodule
